// File: rtl/ps_pkg.sv
// Shared program-sequencer definitions: instruction width, compute opcode field and the
// fetch FSM state encoding.
package ps_pkg;

    localparam int unsigned INST_W      = 48;
    localparam int unsigned OPC_HI      = 47;
    localparam int unsigned OPC_LO      = 45;
    localparam logic [2:0]  OPC_COMPUTE = 3'b001;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } fetch_st_e;

    function automatic logic is_compute(input logic [INST_W-1:0] inst);
        return inst[OPC_HI:OPC_LO] == OPC_COMPUTE;
    endfunction

endpackage

// File: rtl/ps_inst_fetch_if.sv
// Fetch-stage bus: program-memory handshake, jump redirect and decoder-facing issue signals.
interface ps_inst_fetch_if #(
    parameter int unsigned PC_W = 16
);

    logic                        pm_req;
    logic [PC_W-1:0]             pm_addr;
    logic                        pm_ack;
    logic [ps_pkg::INST_W-1:0]   pm_rdata;
    logic                        stall;
    logic                        jmp_en;
    logic [PC_W-1:0]             jmp_addr;
    logic                        iss_vld;
    logic [ps_pkg::INST_W-1:0]   iss_inst;
    logic [PC_W-1:0]             iss_pc;
    logic                        cpt_en;
    logic                        bt_26;
    logic [20:0]                 bt_5t25;

    modport master (
        output pm_req, pm_addr, iss_vld, iss_inst, iss_pc, cpt_en, bt_26, bt_5t25,
        input  pm_ack, pm_rdata, stall, jmp_en, jmp_addr
    );

    modport slave (
        input  pm_req, pm_addr, iss_vld, iss_inst, iss_pc, cpt_en, bt_26, bt_5t25,
        output pm_ack, pm_rdata, stall, jmp_en, jmp_addr
    );

endinterface

// File: rtl/ps_fetch_fifo.sv
// Synchronous FIFO holding fetched {word, pc} entries; flush empties it in a single cycle.
module ps_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   free_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wptr_q - rptr_q;
    assign full_o  = count == (AW+1)'(DEPTH);
    assign empty_o = count == '0;
    assign free_o  = (AW+1)'(DEPTH) - count;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + (AW+1)'(1);
            if (pop_i)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/ps_inst_fetch.sv
// Fetch/issue stage ahead of the compute decoder. Define PS_FETCH_BYPASS_EN to let an acked
// word load an empty issue register directly instead of passing through the FIFO.
module ps_inst_fetch
    import ps_pkg::*;
#(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    ps_inst_fetch_if.master bus
);

    localparam int unsigned ENT_W = INST_W + PC_W;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_st_e         st_q, st_d;
    logic [PC_W-1:0]   fpc_q, fpc_d, drop_addr_q, drop_addr_d;
    logic              iss_vld_q, iss_vld_d;
    logic [INST_W-1:0] iss_inst_q, iss_inst_d;
    logic [PC_W-1:0]   iss_pc_q, iss_pc_d;

    logic              ack_take, consume, can_load, bypass, push, pop;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_free, free_after;
    logic [ENT_W-1:0]  fifo_head;
    logic [INST_W-1:0] inst_out;
    logic              compute;

    ps_fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(ENT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i({bus.pm_rdata, fpc_q}),
        .pop_i      (pop),
        .flush_i    (bus.jmp_en),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .free_o     (fifo_free)
    );

    assign ack_take = (st_q == StReq) && bus.pm_ack && !bus.jmp_en;
    assign consume  = iss_vld_q && !bus.stall;
    assign can_load = !iss_vld_q || consume;
`ifdef PS_FETCH_BYPASS_EN
    assign bypass = ack_take && fifo_empty && can_load;
`else
    assign bypass = 1'b0;
`endif
    assign push       = ack_take && !bypass;
    assign pop        = !bus.jmp_en && can_load && !fifo_empty;
    assign free_after = fifo_free - CNT_W'(push) + CNT_W'(pop);

    always_comb begin
        st_d        = st_q;
        fpc_d       = fpc_q;
        drop_addr_d = drop_addr_q;
        unique case (st_q)
            StIdle: begin
                if (bus.jmp_en) fpc_d = bus.jmp_addr;
                if (bus.jmp_en || !fifo_full) st_d = StReq;
            end
            StReq: begin
                if (bus.jmp_en) begin
                    fpc_d = bus.jmp_addr;
                    // Outstanding request must still be acked; remember its address.
                    if (!bus.pm_ack) begin
                        drop_addr_d = fpc_q;
                        st_d        = StDrop;
                    end
                end else if (bus.pm_ack) begin
                    fpc_d = fpc_q + PC_W'(1);
                    st_d  = (free_after != '0) ? StReq : StIdle;
                end
            end
            StDrop: begin
                if (bus.jmp_en) fpc_d = bus.jmp_addr;
                if (bus.pm_ack) st_d = StReq;
            end
            default: st_d = StIdle;
        endcase
    end

    always_comb begin
        iss_vld_d  = iss_vld_q;
        iss_inst_d = iss_inst_q;
        iss_pc_d   = iss_pc_q;
        if (bus.jmp_en) begin
            iss_vld_d = 1'b0;
        end else if (pop) begin
            iss_vld_d              = 1'b1;
            {iss_inst_d, iss_pc_d} = fifo_head;
        end else if (bypass) begin
            iss_vld_d  = 1'b1;
            iss_inst_d = bus.pm_rdata;
            iss_pc_d   = fpc_q;
        end else if (consume) begin
            iss_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= StIdle;
            fpc_q       <= '0;
            drop_addr_q <= '0;
            iss_vld_q   <= 1'b0;
            iss_inst_q  <= '0;
            iss_pc_q    <= '0;
        end else begin
            st_q        <= st_d;
            fpc_q       <= fpc_d;
            drop_addr_q <= drop_addr_d;
            iss_vld_q   <= iss_vld_d;
            iss_inst_q  <= iss_inst_d;
            iss_pc_q    <= iss_pc_d;
        end
    end

    assign inst_out     = iss_vld_q ? iss_inst_q : '0;
    assign compute      = is_compute(inst_out);
    assign bus.pm_req   = st_q != StIdle;
    assign bus.pm_addr  = (st_q == StReq) ? fpc_q : (st_q == StDrop) ? drop_addr_q : '0;
    assign bus.iss_vld  = iss_vld_q;
    assign bus.iss_inst = inst_out;
    assign bus.iss_pc   = iss_vld_q ? iss_pc_q : '0;
    // Combinational in stall so the decoder sees the consume in the same cycle.
    assign bus.cpt_en   = iss_vld_q && compute && !bus.stall;
    assign bus.bt_26    = compute && inst_out[26];
    assign bus.bt_5t25  = compute ? inst_out[25:5] : '0;

endmodule

// File: doc/ps_inst_fetch.md
# ps_inst_fetch

Program-sequencer fetch and issue stage that sits directly upstream of the compute instruction decoder. It requests 48-bit instruction words from program memory over a req/ack handshake and buffers them in a small FIFO. It presents one issued instruction per cycle and drives the decoder's `cpt_en`, `bt_26` and `bt_5t25` inputs. Jumps flush all buffered and in-flight words.

## Interface
Parameters:
- `PC_W`, 16, program counter / PM address width
- `DEPTH`, 4, instruction FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `pm_req`  out  1  program memory read request
- `pm_addr`  out  PC_W  read address; stable while `pm_req` is high
- `pm_ack`  in  1  read complete; `pm_rdata` valid this cycle
- `pm_rdata`  in  48  instruction word
- `stall`  in  1  downstream cannot consume the issued instruction
- `jmp_en`  in  1  redirect fetch, one-cycle pulse
- `jmp_addr`  in  PC_W  redirect target
- `iss_vld`  out  1  issue register holds a valid instruction
- `iss_inst`  out  48  issued instruction word (0 when `!iss_vld`)
- `iss_pc`  out  PC_W  address of the issued instruction
- `cpt_en`  out  1  issued instruction is compute type and is consumed this cycle
- `bt_26`  out  1  `iss_inst[26]` when compute, else 0
- `bt_5t25`  out  21  `iss_inst[25:5]` when compute, else 0

## Operation
- Compute type: `iss_inst[47:45] == 3'b001`.
- `cpt_en = iss_vld & compute & !stall`. This is combinational from `stall` and must not be registered.
- Consume: an instruction is consumed in any cycle where `iss_vld & !stall`.
- Fetch FSM:
  - IDLE: go to REQ when FIFO free slots exceed 0. In REQ, a request is outstanding.
  - REQ: `pm_req=1` and `pm_addr=fpc`. On `pm_ack`, push `pm_rdata` with its address and increment `fpc` by 1, wrapping at 2^PC_W. Stay in REQ if a slot is still free after the push; otherwise go to IDLE.
  - DROP: `pm_req=1` with the squashed address held. On `pm_ack`, discard the data and go to REQ with `fpc=jmp_addr` already loaded.
- Only one request is outstanding at a time.
- Jump (`jmp_en`):
  - Flush the FIFO and clear `iss_vld`; the current issued instruction is not consumed.
  - Load `fpc=jmp_addr`.
  - If in REQ without `pm_ack` the same cycle, go to DROP.
  - If `pm_ack` coincides, discard the word and go to REQ.
  - `jmp_en` during DROP updates the pending target only.
- Issue register: loads the FIFO head when it is empty or being consumed and the FIFO is non-empty. It clears when it is consumed and the FIFO is empty.
- Push and pop in the same cycle at full: allowed.
- A push into a full FIFO is impossible, because the FSM gates requests on free space.
- Reset values:
  - all outputs 0; FSM in IDLE; `fpc=0`; FIFO empty
  - first request issues the cycle after reset release

## Timing
- `pm_ack` in cycle N → word in FIFO after edge N → issue register after edge N+1 → `iss_vld`/`cpt_en` visible in cycle N+2 when the FIFO was empty.
- Sustained throughput: 1 instruction/cycle when `pm_ack` arrives every cycle.
- Jump in cycle J:
  - new `pm_addr` in cycle J+1 if no request was outstanding or `pm_ack` coincided
  - otherwise new `pm_addr` the cycle after the dropped ack

## Configuration
- `PS_FETCH_BYPASS_EN`:
  - Defined: when the FIFO is empty and the issue register is empty or being consumed, a `pm_ack` word loads the issue register directly. The word becomes visible in cycle N+1 and is not pushed. Jump squashing is unchanged.
  - Undefined: all words pass through the FIFO, giving the N+2 latency above.

## Structure
- Shared package `ps_pkg`:
  - `INST_W=48`
  - compute type code `3'b001` and its field position `[47:45]`
  - fetch FSM state encoding `IDLE/REQ/DROP`
- Sub-module `ps_fetch_fifo`: synchronous FIFO, DEPTH×(48+PC_W), with push, pop, flush, full, empty and free-count outputs.

## Test plan
- Reset, then `pm_ack` every cycle returning `{3'b001,…}` at addresses 0..3 → `pm_addr` 0,1,2,3. `cpt_en` first high in cycle N+2 (N+1 with bypass), then high every cycle with `iss_pc` 0,1,2,3.
- Non-compute word `48'hE000_0000_0000` → `iss_vld=1`, `cpt_en=0`, `bt_5t25=0`, `bt_26=0`.
- Hold `stall=1` for 6 cycles while acks continue → FIFO fills to 4 and `pm_req` drops. `iss_inst` is held and `cpt_en=0`. After release, the 5 buffered instructions issue back to back in order.
- `jmp_en` with `jmp_addr=16'h0100` while a request for address 7 is outstanding and acked 3 cycles later → the ack data is dropped. The next `pm_addr` is `0x0100` and no word from before the jump ever issues.
- `jmp_en` coinciding with `pm_ack` → the word is discarded and `pm_addr=jmp_addr` in the next cycle.
- Start at `fpc=16'hFFFF` via jump → the next fetch address is `16'h0000`.
- Assert `rst` mid-stream → all outputs are 0 immediately, and fetching restarts from 0 after release.
